// File: rtl/shift_add_mul_ctrl.sv
// Sequential 32x32 unsigned multiplier: one shared ripple adder, 32 shift-add steps per operation,
// valid/ready handshakes on both operand and result sides.

module full_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    // Plain ripple chain; each stage is a textbook 1-bit full adder.
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[32];

endmodule

module shift_add_mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        start_ready_q, start_ready_d;
    logic        res_valid_q, res_valid_d;
    logic        busy_q, busy_d;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        carry;

    // lo doubles as the multiplier shift register; its LSB gates the multiplicand.
    assign addend = lo_q[0] ? mcand_q : 32'd0;

    full_adder32 u_adder (
        .a    (hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    state_d = RUN;
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 32'd0;
                    cnt_d   = 5'd0;
                end
            end
            RUN: begin
                // Carry becomes the new MSB of hi so no product bit is ever lost.
                hi_d  = {carry, sum[31:1]};
                lo_d  = {sum[0], lo_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_ready_d = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mcand_q       <= 32'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            cnt_q         <= 5'd0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign product     = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl: directed vectors with literal products plus a
// cycle-level reference model checked on every falling clock edge.

module tb_shift_add_mul_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] product;
   logic        busy;

   int total = 0;
   int bad = 0;
   int completed = 0;
   int dutResults = 0;

   int          mPhase = M_IDLE;
   int          mLeft = 0;
   logic [63:0] mProd = 64'd0;

   shift_add_mul_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .product     (product),
      .busy        (busy)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted pair yields the arithmetic product exactly 32 edges later,
   // and the block sits in a result-holding phase until the consumer takes it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPhase = M_IDLE;
         mLeft  = 0;
         mProd  = 64'd0;
      end else begin
         case (mPhase)
            M_IDLE: if (start_valid) begin
               mProd  = {32'd0, a} * {32'd0, b};
               mLeft  = 32;
               mPhase = M_RUN;
            end
            M_RUN: begin
               mLeft = mLeft - 1;
               if (mLeft == 0) mPhase = M_DONE;
            end
            default: if (res_ready) mPhase = M_IDLE;
         endcase
      end
   end

   // Falling-edge comparison of every observable output against the model.
   always @(negedge clk) begin
      checkOutput("start_ready", {63'd0, start_ready}, {63'd0, (mPhase == M_IDLE)});
      checkOutput("res_valid", {63'd0, res_valid}, {63'd0, (mPhase == M_DONE)});
      checkOutput("busy", {63'd0, busy}, {63'd0, (mPhase != M_IDLE)});
      if (mPhase != M_RUN) checkOutput("product", product, mProd);
      if (res_valid && res_ready) dutResults++;
   end

   // One complete operation: wait for ready, hand over operands, wait for the result,
   // stall the consumer for a while, then take the product.
   task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tbv, input int stall,
                                input bit noise, output logic [63:0] prod);
      int waited = 0;
      int lat = 0;
      while (!start_ready && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("ready_wait", {63'd0, start_ready}, 64'd1);
      a = ta;
      b = tbv;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      while (!res_valid && lat < 100) begin
         if (noise) begin
            start_valid = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            res_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         lat++;
      end
      start_valid = 1'b0;
      res_ready = 1'b0;
      checkOutput("latency", 64'(lat), 64'd32);
      repeat (stall) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", {63'd0, res_valid}, 64'd1);
      end
      prod = product;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      completed++;
      checkOutput("idle_ready", {63'd0, start_ready}, 64'd1);
      checkOutput("idle_valid", {63'd0, res_valid}, 64'd0);
   endtask

   // Directed vectors first, then a mid-run reset, then a long random soak.
   initial begin
      logic [63:0] prod;
      logic [31:0] ra, rb;
      rst_n = 1'b0;
      start_valid = 1'b0;
      res_ready = 1'b0;
      a = 32'd0;
      b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_product", product, 64'd0);
      rst_n = 1'b1;

      applyStimulus(32'd3, 32'd5, 0, 1'b0, prod);
      checkOutput("p_3x5", prod, 64'h0000_0000_0000_000F);
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, prod);
      checkOutput("p_max", prod, 64'hFFFF_FFFE_0000_0001);
      applyStimulus(32'd0, 32'h1234_5678, 1, 1'b0, prod);
      checkOutput("p_zero", prod, 64'd0);
      applyStimulus(32'hDEAD_BEEF, 32'd2, 10, 1'b0, prod);
      checkOutput("p_stall", prod, 64'h0000_0001_BD5B_7DDE);
      applyStimulus(32'h1234, 32'h10, 2, 1'b1, prod);
      checkOutput("p_noise", prod, 64'h0000_0000_0001_2340);

      a = 32'd9;
      b = 32'd9;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("abort_busy", {63'd0, busy}, 64'd0);
      checkOutput("abort_product", product, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(32'd7, 32'd6, 0, 1'b0, prod);
      checkOutput("p_7x6", prod, 64'd42);

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), prod);
         checkOutput("p_rand", prod, {32'd0, ra} * {32'd0, rb});
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("result_count", 64'(dutResults), 64'(completed));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_mul_ctrl.md
SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits by the shared full_adder32 instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start_valid  input  1  requester presents operands a, b.
REQ-005 start_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  32  multiplicand, unsigned; sampled at start handshake.
REQ-007 b  input  32  multiplier, unsigned; sampled at start handshake.
REQ-008 res_valid  output  1  product is valid; high only in DONE.
REQ-009 res_ready  input  1  consumer accepts product.
REQ-010 product  output  64  unsigned a*b.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL sequence exactly one full_adder32 instance as the only adder in the datapath; no other "+" operator on 32-bit data.
REQ-013 State SHALL be {IDLE, RUN, DONE}; transitions: IDLE->RUN on start_valid&&start_ready; RUN->DONE when step counter reaches 31; DONE->IDLE on res_valid&&res_ready; all others hold.
REQ-014 Start handshake edge SHALL load mcand<=a, lo<=b, hi<=0, cnt<=0.
REQ-015 Each RUN cycle: addend = lo[0] ? mcand : 0; {c,sum} = hi + addend via full_adder32 (carry-in 0); hi<={c,sum[31:1]}; lo<={sum[0],lo[31:1]}; cnt<=cnt+1.
REQ-016 cnt SHALL be 5 bits; exactly 32 RUN cycles per operation, independent of operand values (no early exit).
REQ-017 Latency: handshake on edge k -> res_valid high after edge k+32, product valid in the same cycle.
REQ-018 product SHALL equal {hi,lo}; it SHALL be held stable while res_valid=1 and res_ready=0, for any number of cycles.
REQ-019 start_valid in RUN or DONE SHALL be ignored (start_ready=0); a, b changes outside the handshake edge SHALL NOT affect the result.
REQ-020 No same-cycle turnaround: after the result handshake, state is IDLE for at least one cycle before the next accept.
REQ-021 res_ready while not in DONE SHALL have no effect.
REQ-022 Carry out of bit 31 SHALL never be dropped; the result is the exact 64-bit product for all operand values, including 0xFFFFFFFF*0xFFFFFFFF.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, hi=0, lo=0, mcand=0, cnt=0; outputs start_ready=1 (once rst_n is high), res_valid=0, busy=0, product=0.
REQ-024 Reset asserted during RUN or DONE SHALL abandon the operation; no res_valid for it after release.
REQ-025 Reset deassertion SHALL take effect at the next rising clk; first accept possible on the first edge after release.

Verification
REQ-026 a=3, b=5, res_ready=1 -> res_valid 32 cycles after accept, product=0x0000_0000_0000_000F, then IDLE.
REQ-027 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE_00000001; a=0, b=0x12345678 -> product=0.
REQ-028 res_ready=0 for 10 cycles in DONE -> res_valid stays 1, product unchanged; release -> IDLE next cycle, start_ready=1.
REQ-029 start_valid pulsed with new a, b during RUN -> ignored; result still matches the original operands.
REQ-030 rst_n low at RUN cycle 15 -> immediate IDLE, res_valid=0; new accept a=7, b=6 -> product=42 after 32 cycles.
REQ-031 1000 random a, b back-to-back with random res_ready stalls -> every product matches a 64-bit reference model; no lost or duplicated results.
